// File: rtl/dsa_pixel_fetch_lanes.sv
// 2x2 neighbourhood fetch for 1..LANES pixels on one source row; out_valid R+2 edges after accept, held until out_ready.
// Neighbour reuse between adjacent lanes is compiled in when DSA_FETCH_REUSE_EN is defined.
module dsa_pixel_fetch_lanes #(
  parameter int ADDR_WIDTH = 18,
  parameter int LANES      = 4,
  parameter int FRAC_BITS  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [15:0]                base_x,
  input  logic [15:0]                step_x,
  input  logic [15:0]                src_y,
  input  logic [7:0]                 lane_count,
  input  logic [15:0]                img_width,
  input  logic [15:0]                img_height,
  input  logic [ADDR_WIDTH-1:0]      img_base_addr,
  output logic                       mem_read_en,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  input  logic [7:0]                 mem_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*8-1:0]         out_p00,
  output logic [LANES*8-1:0]         out_p01,
  output logic [LANES*8-1:0]         out_p10,
  output logic [LANES*8-1:0]         out_p11,
  output logic [LANES*FRAC_BITS-1:0] out_frac_x,
  output logic [LANES*FRAC_BITS-1:0] out_frac_y,
  output logic [LANES-1:0]           out_lane_mask,
  output logic [7:0]                 out_reads
);
  localparam int NSLOT = 4 * LANES;
  localparam int IDXW  = $clog2(NSLOT);
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_READ, S_DRAIN, S_DONE} state_e;
  state_e state_q, state_d;

  logic [15:0]           base_x_q, step_x_q, src_y_q, w_q, h_q;
  logic [7:0]            n_q;
  logic [ADDR_WIDTH-1:0] img_base_q;
  logic [IDXW-1:0]       rd_idx_q, rd_idx_d;
  logic                  cap_vld_q;
  logic [IDXW-1:0]       cap_idx_q;
  logic [7:0]            raw_q [NSLOT];

  logic accept;
  assign accept = req_valid && (state_q == S_IDLE);

  // Per-lane coordinates are derived combinationally from the latched request.
  logic [15:0]      lane_x [LANES];
  logic [15:0]      xi     [LANES];
  logic [15:0]      x0     [LANES];
  logic [15:0]      x1     [LANES];
  logic [LANES-1:0] lane_act;
  logic [15:0]      wmax, hmax, yi, y0, y1;

  assign wmax = w_q - 16'd1;
  assign hmax = h_q - 16'd1;
  assign yi   = src_y_q >> FRAC_BITS;
  assign y0   = (yi > hmax) ? hmax : yi;
  assign y1   = (({1'b0, yi} + 17'd1) > {1'b0, hmax}) ? hmax : yi + 16'd1;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_x[i]   = base_x_q + step_x_q * 16'(i);
      xi[i]       = lane_x[i] >> FRAC_BITS;
      x0[i]       = (xi[i] > wmax) ? wmax : xi[i];
      x1[i]       = (({1'b0, xi[i]} + 17'd1) > {1'b0, wmax}) ? wmax : xi[i] + 16'd1;
      lane_act[i] = (8'(i) < n_q);
    end
  end

  // need[4*i+s]: slot s (p00,p01,p10,p11) of lane i must be read from memory.
  logic [NSLOT-1:0] need;
  logic [LANES-1:0] copy_all, copy_half;

  always_comb begin
    need      = '0;
    copy_all  = '0;
    copy_half = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_act[i]) need[4*i +: 4] = 4'b1111;
    end
`ifdef DSA_FETCH_REUSE_EN
    for (int i = 1; i < LANES; i++) begin
      if (lane_act[i]) begin
        if (x0[i] == x0[i-1]) begin
          copy_all[i]     = 1'b1;
          need[4*i +: 4]  = 4'b0000;
        end else if (x0[i] == x1[i-1]) begin
          copy_half[i]    = 1'b1;
          need[4*i +: 4]  = 4'b1010;
        end
      end
    end
`endif
  end

  logic            has_first, has_next;
  logic [IDXW-1:0] first_idx, next_idx;

  always_comb begin
    has_first = 1'b0;
    first_idx = '0;
    has_next  = 1'b0;
    next_idx  = '0;
    for (int k = NSLOT - 1; k >= 0; k--) begin
      if (need[k]) begin
        has_first = 1'b1;
        first_idx = IDXW'(k);
        if (k > int'(rd_idx_q)) begin
          has_next = 1'b1;
          next_idx = IDXW'(k);
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rd_idx_d = rd_idx_q;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = S_CALC;
      S_CALC: begin
        if (has_first) begin
          state_d  = S_READ;
          rd_idx_d = first_idx;
        end else begin
          state_d  = S_DRAIN;
        end
      end
      S_READ: begin
        if (has_next) rd_idx_d = next_idx;
        else          state_d  = S_DRAIN;
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rd_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      rd_idx_q <= rd_idx_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_x_q   <= '0;
      step_x_q   <= '0;
      src_y_q    <= '0;
      w_q        <= '0;
      h_q        <= '0;
      n_q        <= '0;
      img_base_q <= '0;
      cap_vld_q  <= 1'b0;
      cap_idx_q  <= '0;
      for (int k = 0; k < NSLOT; k++) raw_q[k] <= '0;
    end else begin
      if (accept) begin
        base_x_q   <= base_x;
        step_x_q   <= step_x;
        src_y_q    <= src_y;
        w_q        <= (img_width == 16'd0) ? 16'd1 : img_width;
        h_q        <= (img_height == 16'd0) ? 16'd1 : img_height;
        n_q        <= (lane_count == 8'd0) ? 8'd1 :
                      (lane_count > 8'(LANES)) ? 8'(LANES) : lane_count;
        img_base_q <= img_base_addr;
        for (int k = 0; k < NSLOT; k++) raw_q[k] <= '0;
      end
      // Read data arrives the cycle after issue; land it in the slot it was issued for.
      cap_vld_q <= (state_q == S_READ);
      cap_idx_q <= rd_idx_q;
      if (cap_vld_q) raw_q[cap_idx_q] <= mem_data;
    end
  end

  logic [LW-1:0]         rd_lane;
  logic [15:0]           rd_x, rd_y;
  logic [ADDR_WIDTH-1:0] rd_prod, rd_addr;

  assign rd_lane = LW'(rd_idx_q >> 2);
  assign rd_x    = rd_idx_q[0] ? x1[rd_lane] : x0[rd_lane];
  assign rd_y    = rd_idx_q[1] ? y1 : y0;
  assign rd_prod = ADDR_WIDTH'({16'd0, rd_y} * {16'd0, w_q});
  assign rd_addr = img_base_q + rd_prod + ADDR_WIDTH'(rd_x);

  assign req_ready   = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign mem_read_en = (state_q == S_READ);
  assign mem_addr    = mem_read_en ? rd_addr : '0;

  // Reused slots point back through the previous lane's resolved sources.
  logic [7:0] pix [NSLOT];

  always_comb begin : resolve
    logic [IDXW-1:0] prv [4];
    logic [IDXW-1:0] cur [4];
    for (int s = 0; s < 4; s++) begin
      prv[s] = '0;
      cur[s] = '0;
    end
    for (int k = 0; k < NSLOT; k++) pix[k] = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int s = 0; s < 4; s++) cur[s] = IDXW'(4 * i + s);
      if (copy_all[i]) begin
        for (int s = 0; s < 4; s++) cur[s] = prv[s];
      end else if (copy_half[i]) begin
        cur[0] = prv[1];
        cur[2] = prv[3];
      end
      for (int s = 0; s < 4; s++) begin
        pix[4*i+s] = raw_q[cur[s]];
        prv[s]     = cur[s];
      end
    end
  end

  logic [15:0] rd_total;

  always_comb begin
    rd_total = '0;
    for (int k = 0; k < NSLOT; k++) rd_total = rd_total + 16'(need[k]);
  end

  assign out_reads = !out_valid ? 8'd0 : (rd_total > 16'd255) ? 8'd255 : rd_total[7:0];

  always_comb begin
    out_p00       = '0;
    out_p01       = '0;
    out_p10       = '0;
    out_p11       = '0;
    out_frac_x    = '0;
    out_frac_y    = '0;
    out_lane_mask = '0;
    if (out_valid) begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_act[i]) begin
          out_p00[8*i +: 8]                  = pix[4*i];
          out_p01[8*i +: 8]                  = pix[4*i+1];
          out_p10[8*i +: 8]                  = pix[4*i+2];
          out_p11[8*i +: 8]                  = pix[4*i+3];
          out_frac_x[FRAC_BITS*i +: FRAC_BITS] = lane_x[i][FRAC_BITS-1:0];
          out_frac_y[FRAC_BITS*i +: FRAC_BITS] = src_y_q[FRAC_BITS-1:0];
          out_lane_mask[i]                   = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dsa_pixel_fetch_lanes.sv
// Directed bench for dsa_pixel_fetch_lanes on an 8x8 image whose byte at address a is a[7:0].
module tb_dsa_pixel_fetch_lanes;
  localparam int AW = 18;
  localparam int LN = 4;
  localparam int FB = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready;
  logic [15:0]   base_x, step_x, src_y, img_width, img_height;
  logic [7:0]    lane_count;
  logic [AW-1:0] img_base_addr;
  logic          mem_read_en;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data = 8'd0;
  logic          out_valid, out_ready;
  logic [LN*8-1:0]  out_p00, out_p01, out_p10, out_p11;
  logic [LN*FB-1:0] out_frac_x, out_frac_y;
  logic [LN-1:0]    out_lane_mask;
  logic [7:0]       out_reads;

  int checks = 0;
  int errors = 0;
  int lat;

`ifdef DSA_FETCH_REUSE_EN
  localparam int R4L = 6;
  localparam int R2L = 6;
`else
  localparam int R4L = 16;
  localparam int R2L = 8;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_read_en) mem_data <= mem_addr[7:0];

  dsa_pixel_fetch_lanes #(.ADDR_WIDTH(AW), .LANES(LN), .FRAC_BITS(FB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .base_x(base_x), .step_x(step_x), .src_y(src_y), .lane_count(lane_count),
    .img_width(img_width), .img_height(img_height), .img_base_addr(img_base_addr),
    .mem_read_en(mem_read_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p00(out_p00), .out_p01(out_p01), .out_p10(out_p10), .out_p11(out_p11),
    .out_frac_x(out_frac_x), .out_frac_y(out_frac_y),
    .out_lane_mask(out_lane_mask), .out_reads(out_reads)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Issue one request and return the number of rising edges from accept to out_valid.
  task automatic run_req(input logic [15:0] bx, input logic [15:0] sx, input logic [15:0] sy,
                         input logic [7:0] n, output int edges);
    @(negedge clk);
    chk("req_ready_before", {31'd0, req_ready}, 32'd1);
    base_x = bx; step_x = sx; src_y = sy; lane_count = n;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    base_x = 16'hFFFF; step_x = 16'hFFFF; src_y = 16'hFFFF; lane_count = 8'd0;
    edges = 0;
    while (!out_valid && edges < 200) begin
      @(posedge clk);
      edges++;
      #1;
    end
    if (!out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic pop();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("req_ready_after_pop", {31'd0, req_ready}, 32'd1);
    chk("out_valid_after_pop", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; out_ready = 1'b0;
    base_x = '0; step_x = '0; src_y = '0; lane_count = '0;
    img_width = 16'd8; img_height = 16'd8; img_base_addr = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mem_read_en", {31'd0, mem_read_en}, 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_p00", out_p00, 32'd0);
    chk("rst_frac_x", out_frac_x, 32'd0);
    chk("rst_mask", 32'(out_lane_mask), 32'd0);
    chk("rst_reads", 32'(out_reads), 32'd0);

    // Single lane
    run_req(16'h0280, 16'h0000, 16'h0140, 8'd1, lat);
    chk("s1_latency", lat, 32'd6);
    chk("s1_p00", out_p00, 32'h0000000A);
    chk("s1_p01", out_p01, 32'h0000000B);
    chk("s1_p10", out_p10, 32'h00000012);
    chk("s1_p11", out_p11, 32'h00000013);
    chk("s1_frac_x", out_frac_x, 32'h00000080);
    chk("s1_frac_y", out_frac_y, 32'h00000040);
    chk("s1_reads", 32'(out_reads), 32'd4);
    chk("s1_mask", 32'(out_lane_mask), 32'h1);
    pop();

    // Edge clamp
    run_req(16'h0780, 16'h0000, 16'h0700, 8'd1, lat);
    chk("clamp_p00", out_p00, 32'h0000003F);
    chk("clamp_p01", out_p01, 32'h0000003F);
    chk("clamp_p10", out_p10, 32'h0000003F);
    chk("clamp_p11", out_p11, 32'h0000003F);
    chk("clamp_frac_x", out_frac_x, 32'h00000080);
    chk("clamp_frac_y", out_frac_y, 32'h00000000);
    pop();

    // Four lanes
    run_req(16'h0100, 16'h0080, 16'h0000, 8'd4, lat);
    chk("l4_latency", lat, R4L + 2);
    chk("l4_p00", out_p00, 32'h02020101);
    chk("l4_p01", out_p01, 32'h03030202);
    chk("l4_p10", out_p10, 32'h0A0A0909);
    chk("l4_p11", out_p11, 32'h0B0B0A0A);
    chk("l4_frac_x", out_frac_x, 32'h80008000);
    chk("l4_reads", 32'(out_reads), R4L);
    chk("l4_mask", 32'(out_lane_mask), 32'hF);
    pop();

    // Backpressure with two active lanes
    run_req(16'h0100, 16'h0100, 16'h0200, 8'd2, lat);
    chk("bp_latency", lat, R2L + 2);
    repeat (5) @(negedge clk);
    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
    chk("bp_p00", out_p00, 32'h00001211);
    chk("bp_p01", out_p01, 32'h00001312);
    chk("bp_p10", out_p10, 32'h00001A19);
    chk("bp_p11", out_p11, 32'h00001B1A);
    chk("bp_frac_y", out_frac_y, 32'h00000000);
    chk("bp_mask", 32'(out_lane_mask), 32'h3);
    chk("bp_reads", 32'(out_reads), R2L);
    pop();

    // Reset during the third READ cycle
    @(negedge clk);
    base_x = 16'h0100; step_x = 16'h0080; src_y = 16'h0000; lane_count = 8'd4;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("mid_read_en", {31'd0, mem_read_en}, 32'd1);
    chk("mid_addr", 32'(mem_addr), 32'd9);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_read_en", {31'd0, mem_read_en}, 32'd0);
    chk("mid_rst_addr", 32'(mem_addr), 32'd0);
    chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    run_req(16'h0280, 16'h0000, 16'h0140, 8'd1, lat);
    chk("post_rst_latency", lat, 32'd6);
    chk("post_rst_p11", out_p11, 32'h00000013);
    chk("post_rst_reads", 32'(out_reads), 32'd4);
    pop();

    // lane_count of zero is one lane
    run_req(16'h0280, 16'h0000, 16'h0140, 8'd0, lat);
    chk("n0_mask", 32'(out_lane_mask), 32'h1);
    chk("n0_reads", 32'(out_reads), 32'd4);
    chk("n0_p00", out_p00, 32'h0000000A);
    pop();

    // lane_count above LANES saturates; distinct columns mean no reuse
    run_req(16'h0000, 16'h0200, 16'h0000, 8'd7, lat);
    chk("n7_latency", lat, 32'd18);
    chk("n7_mask", 32'(out_lane_mask), 32'hF);
    chk("n7_reads", 32'(out_reads), 32'd16);
    chk("n7_p00", out_p00, 32'h06040200);
    chk("n7_p11", out_p11, 32'h0F0D0B09);
    pop();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsa_pixel_fetch_lanes.md
# dsa_pixel_fetch_lanes

Parametrised, single-master pixel fetch engine for the bilinear interpolation DSA: one request fetches the 2×2 neighbourhood (p00, p01, p10, p11) for 1..LANES output pixels on the same source row. Lane x coordinates come from a fixed-point base and step, and edge coordinates are clamped. It replaces the separate sequential and SIMD fetch paths: sequential mode is `lane_count = 1`. It sits between the coordinate generator and the interpolation datapath, owns the image-memory read port, and uses valid/ready on both sides.

## Interface
Parameters:
- ADDR_WIDTH, 18, image memory address width
- LANES, 4, maximum lanes per request (≥1)
- FRAC_BITS, 8, fractional bits of the 16-bit coordinates (integer part = 16−FRAC_BITS bits)

Ports:
- clk  in  1  single clock; all logic is rising-edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid / req_ready  in / out  1 / 1  request handshake; req_ready=1 only in IDLE
- base_x, step_x, src_y  in  16 each  fixed-point lane-0 x, per-lane x increment, row y
- lane_count  in  8  active lanes; 0 is treated as 1, values >LANES saturate to LANES
- img_width, img_height  in  16 each  image size; 0 is treated as 1
- img_base_addr  in  ADDR_WIDTH  image base address
- mem_read_en, mem_addr  out  1, ADDR_WIDTH  read port
- mem_data  in  8  read data, valid exactly 1 cycle after mem_read_en
- out_valid / out_ready  out / in  1 / 1  result handshake
- out_p00, out_p01, out_p10, out_p11  out  LANES*8 each  lane i at [8i+7:8i]
- out_frac_x, out_frac_y  out  LANES*FRAC_BITS each  lane i fractional parts
- out_lane_mask  out  LANES  bit i = lane i valid
- out_reads  out  8  memory reads issued for this result

## Operation
- Accept: on req_valid && req_ready, all inputs are latched and the block moves IDLE→CALC. Later input changes are ignored.
- CALC (1 cycle), per lane i < n:
  - x_i = base_x + i*step_x, 16-bit wrapping.
  - xi = x_i >> FRAC_BITS; x0 = min(xi, W−1); x1 = min(xi+1, W−1); y0/y1 are formed the same way from src_y against H−1.
  - frac = low FRAC_BITS bits, unclamped.
  - Lanes ≥ n output 0 for pixels, fracs and mask bits.
- READ: one read per cycle, lane order 0..n−1, and within a lane p00, p01, p10, p11.
  - addr = img_base_addr + y*img_width + x, truncated to ADDR_WIDTH.
  - Each returned byte is written into its slot one cycle after issue.
- DRAIN (1 cycle): captures the last read.
- DONE: out_valid=1. Outputs are stable until out_ready. On the handshake edge the block returns to IDLE.
- Transitions: IDLE→CALC→READ→DRAIN→DONE→IDLE. If zero reads are needed, CALC goes directly to DRAIN.
- Reset at any time, including mid-READ: the block returns to IDLE immediately, the in-flight read data is discarded, and no out_valid is produced.

## Timing
- Reset values:
  - req_ready=1 (IDLE, once reset is released).
  - All other outputs 0, including mem_read_en, mem_addr, out_valid, all pixel/frac buses, out_lane_mask and out_reads.
- mem_read_en/mem_addr are asserted in READ cycles only. There are no bubbles between reads.
- With R reads, out_valid rises R+2 rising edges after the accepting edge. Examples: R=4 gives 6; R=16 gives 18.
- req_ready returns to 1 in the cycle after the out handshake. A request and an output handshake never overlap.
- out_reads = R, saturating at 255.

## Configuration
- DSA_FETCH_REUSE_EN defined: neighbour reuse is enabled for lanes i ≥ 1.
  - If x0_i == x0_{i−1}, all four pixels are copied from lane i−1 and no reads are issued.
  - Else if x0_i == x1_{i−1}, p00_i←p01_{i−1} and p10_i←p11_{i−1}, and only p01 and p11 are read.
  - Copies happen after the source data is captured.
- Undefined: every active lane issues 4 reads, so R = 4n.

## Test plan
Common setup: W=H=8, base=0, memory byte = addr[7:0].
- Single lane: n=1, base_x=0x0280, src_y=0x0140 → p00=10, p01=11, p10=18, p11=19; frac_x=0x80, frac_y=0x40; out_reads=4; out_valid 6 edges after accept.
- Edge clamp: base_x=0x0780, src_y=0x0700 → all four pixels = 63; frac_x=0x80, frac_y=0x00.
- Four lanes: base_x=0x0100, step_x=0x0080, src_y=0.
  - Lane 0: 1/2/9/10. Lane 2: 2/3/10/11. Lanes 1 and 3 equal lanes 0 and 2 respectively.
  - out_reads=6 with DSA_FETCH_REUSE_EN; 16 without.
- Backpressure and masking: n=2 with out_ready held low for 5 cycles → outputs stable, req_ready=0, out_lane_mask=4'b0011, lanes 2–3 zero. After release, req_ready=1 in the next cycle.
- Reset mid-operation: assert rst_n=0 during the 3rd READ cycle → all outputs reach reset values at once. A fresh request then completes correctly.
- Lane count limits: lane_count=0 → mask 0001, 4 reads. lane_count=7 with LANES=4 → mask 1111.
